// File: rtl/jtag_lint_apb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// jtag_lint_apb_pkg
// Shared definitions for the JTAG LINT to APB bridge:
//   - FSM state encodings (2-bit, plain constants so legacy tools can read
//     them)
//   - LINT r_opc codes
//   - counter width helper for the ACCESS timeout counter
// ---------------------------------------------------------------------------
package jtag_lint_apb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam logic LINT_OPC_OK  = 1'b0;
  localparam logic LINT_OPC_ERR = 1'b1;

  // Width needed to count 0 .. n-1. A 0 or 1 cycle limit still gets one bit,
  // so the counter declaration stays legal.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtag_lint_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for the JTAG LINT to APB bridge.
//   jtag_lint_if : XBAR_TCDM_BUS style request/grant/r_valid bus
//                  master drives req/add/wen/wdata/be,
//                  slave drives gnt/r_valid/r_rdata/r_opc
//   jtag_apb_if  : APB3 bus with byte strobes
//                  master drives paddr/pwdata/pwrite/pstrb/psel/penable,
//                  slave drives prdata/pready/pslverr
// ---------------------------------------------------------------------------
interface jtag_lint_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    gnt;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_opc;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

interface jtag_apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic                    pwrite;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    psel;
  logic                    penable;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, pwdata, pwrite, pstrb, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, pstrb, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/jtag_lint_apb_bridge_core.sv
// ---------------------------------------------------------------------------
// jtag_lint_apb_bridge_core
// Bridge engine working on interface modports. Accepts one LINT transaction,
// runs it as one APB SETUP/ACCESS pair and answers with a one-cycle r_valid.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   lint          : jtag_lint_if.slave (request side from the debug unit)
//   apb           : jtag_apb_if.master (towards the peripheral)
// ---------------------------------------------------------------------------
module jtag_lint_apb_bridge_core
  import jtag_lint_apb_pkg::*;
#(
  parameter int                    LINT_ADDR_WIDTH = 32,
  parameter int                    APB_ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    TIMEOUT_CYCLES  = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  jtag_lint_if.slave  lint,
  jtag_apb_if.master  apb
);

  localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_pwrite;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_opc;

  logic w_timeout;

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Grant is combinational in IDLE; it is also held low during reset so
  // every output reads 0 while rst_ni is asserted.
  assign lint.gnt     = rst_ni && (r_state == ST_IDLE) && lint.req;
  assign lint.r_valid = (r_state == ST_RESP);
  assign lint.r_rdata = r_rdata;
  assign lint.r_opc   = r_opc;

  assign apb.psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign apb.penable = (r_state == ST_ACCESS);
  assign apb.paddr   = r_paddr;
  assign apb.pwdata  = r_pwdata;
  assign apb.pwrite  = r_pwrite;
  assign apb.pstrb   = r_pstrb;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= '0;
      r_rdata  <= '0;
      r_opc    <= LINT_OPC_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (lint.req) begin
            r_paddr  <= lint.add[APB_ADDR_WIDTH-1:0];
            r_pwdata <= lint.wdata;
            r_pwrite <= ~lint.wen;
            // Reads carry no strobes on APB
            r_pstrb  <= lint.wen ? '0 : lint.be;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // pready has priority over a timeout landing in the same cycle
          if (apb.pready) begin
            r_rdata <= r_pwrite ? '0 : apb.prdata;
            r_opc   <= apb.pslverr ? LINT_OPC_ERR : LINT_OPC_OK;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_rdata <= r_pwrite ? '0 : ERR_RDATA;
            r_opc   <= LINT_OPC_ERR;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/jtag_lint_apb_bridge.sv
// ---------------------------------------------------------------------------
// jtag_lint_apb_bridge
// Lets the JTAG debug LINT master reach one APB3 peripheral port directly.
// Flat-port top: binds the LINT and APB ports to bus interfaces and runs the
// bridge core on them.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   lint_req_i .. lint_be_i: LINT request (wen=1 read, 0 write)
//   lint_gnt_o             : grant, combinational in IDLE
//   lint_r_valid_o/_rdata_o/_opc_o : one-cycle response, opc=1 on error
//   paddr_o .. penable_o   : APB master outputs (registered)
//   prdata_i/pready_i/pslverr_i : APB slave response
// ---------------------------------------------------------------------------
module jtag_lint_apb_bridge #(
  parameter int                    LINT_ADDR_WIDTH = 32,
  parameter int                    APB_ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    TIMEOUT_CYCLES  = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       lint_req_i,
  input  logic [LINT_ADDR_WIDTH-1:0] lint_add_i,
  input  logic                       lint_wen_i,
  input  logic [DATA_WIDTH-1:0]      lint_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    lint_be_i,
  output logic                       lint_gnt_o,
  output logic                       lint_r_valid_o,
  output logic [DATA_WIDTH-1:0]      lint_r_rdata_o,
  output logic                       lint_r_opc_o,
  output logic [APB_ADDR_WIDTH-1:0]  paddr_o,
  output logic [DATA_WIDTH-1:0]      pwdata_o,
  output logic                       pwrite_o,
  output logic [DATA_WIDTH/8-1:0]    pstrb_o,
  output logic                       psel_o,
  output logic                       penable_o,
  input  logic [DATA_WIDTH-1:0]      prdata_i,
  input  logic                       pready_i,
  input  logic                       pslverr_i
);

  jtag_lint_if #(.ADDR_WIDTH(LINT_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lint ();
  jtag_apb_if  #(.ADDR_WIDTH(APB_ADDR_WIDTH),  .DATA_WIDTH(DATA_WIDTH)) u_apb ();

  assign u_lint.req   = lint_req_i;
  assign u_lint.add   = lint_add_i;
  assign u_lint.wen   = lint_wen_i;
  assign u_lint.wdata = lint_wdata_i;
  assign u_lint.be    = lint_be_i;

  assign lint_gnt_o     = u_lint.gnt;
  assign lint_r_valid_o = u_lint.r_valid;
  assign lint_r_rdata_o = u_lint.r_rdata;
  assign lint_r_opc_o   = u_lint.r_opc;

  assign paddr_o   = u_apb.paddr;
  assign pwdata_o  = u_apb.pwdata;
  assign pwrite_o  = u_apb.pwrite;
  assign pstrb_o   = u_apb.pstrb;
  assign psel_o    = u_apb.psel;
  assign penable_o = u_apb.penable;

  assign u_apb.prdata  = prdata_i;
  assign u_apb.pready  = pready_i;
  assign u_apb.pslverr = pslverr_i;

  jtag_lint_apb_bridge_core #(
    .LINT_ADDR_WIDTH (LINT_ADDR_WIDTH),
    .APB_ADDR_WIDTH  (APB_ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .ERR_RDATA       (ERR_RDATA)
  ) u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lint   (u_lint),
    .apb    (u_apb)
  );

endmodule

// File: doc/jtag_lint_apb_bridge.md
Name: jtag_lint_apb_bridge

Overview:
- Slave-side converter between the JTAG debug LINT master (XBAR_TCDM_BUS request/grant/r_valid protocol) and a single APB3 peripheral port.
- Lets the debug path reach SoC control registers without going through the interconnect.
- Accepts one LINT transaction at a time and runs it as one APB setup/access pair.
- Returns the result as a single-cycle r_valid pulse, with error reporting on r_opc and a programmable access timeout.

Parameters:
- LINT_ADDR_WIDTH, 32, width of LINT address.
- APB_ADDR_WIDTH, 32, width of paddr_o; takes the LSBs of the latched LINT address.
- DATA_WIDTH, 32, data width of both sides; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.
- ERR_RDATA, 32'hBADACCE5, value returned on r_rdata_o for a timed-out read.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- lint_req_i  in  1  LINT request
- lint_add_i  in  LINT_ADDR_WIDTH  byte address
- lint_wen_i  in  1  1 = read, 0 = write (PULP convention)
- lint_wdata_i  in  DATA_WIDTH  write data
- lint_be_i  in  DATA_WIDTH/8  byte enables
- lint_gnt_o  out  1  grant
- lint_r_valid_o  out  1  response valid, single-cycle pulse
- lint_r_rdata_o  out  DATA_WIDTH  read data
- lint_r_opc_o  out  1  0 = OK, 1 = error (pslverr or timeout)
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  DATA_WIDTH  APB write data
- pwrite_o  out  1  APB direction
- pstrb_o  out  DATA_WIDTH/8  APB strobes
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is synchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - lint_gnt_o = lint_req_i (combinational).
  - On req&gnt, register the address (truncated to APB_ADDR_WIDTH), wdata, be, and pwrite = ~wen; go to SETUP.
- SETUP: psel_o=1, penable_o=0; unconditionally go to ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1; the timeout counter increments each cycle.
  - pready_i=1: capture prdata_i (reads only; writes capture 0) and pslverr_i; go to RESP.
  - TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1 with pready_i=0: abort.
  - Abort effects: capture rdata = ERR_RDATA for reads (0 for writes) and opc=1; go to RESP.
  - pready and timeout in the same cycle: pready wins and the normal response is used.
- RESP:
  - lint_r_valid_o=1 for exactly one cycle, with r_rdata/r_opc from the captured registers.
  - psel_o=0; return to IDLE.
  - Counter cleared.
- Grant rule: lint_gnt_o=0 in SETUP, ACCESS and RESP. Minimum request-to-request spacing is 4 cycles; r_valid arrives 3 cycles after grant when pready is immediate.
- APB output stability: paddr/pwdata/pwrite/pstrb are registers, stable from SETUP through the final ACCESS cycle.
- Read strobes: pstrb_o is forced to 0 for reads, per APB3/4.
- Register holding: r_rdata_o and r_opc_o hold their last value outside RESP; only r_valid qualifies them.
- Reset mid-transaction: the FSM returns to IDLE in the next cycle and psel/penable/r_valid drop. No response is issued; the debug side is reset by the same domain.
- Input sampling: lint_req_i deassertion while not granted is legal and has no effect. Inputs are sampled only at the grant.

Decomposition:
- Package jtag_lint_apb_pkg:
  - FSM state enum (2-bit).
  - Constants LINT_OPC_OK=1'b0 and LINT_OPC_ERR=1'b1.
  - Function clog2-based counter width.
- Sub-module: none natural. The timeout counter is inline.
- Instantiation: a thin interface wrapper binds XBAR_TCDM_BUS.Slave and APB_BUS.Master to the flat ports.

Test Plan:
- Read, pready on first ACCESS cycle:
  - Stimulus: req, wen=1, add=32'h1A10_4004; prdata=32'hCAFE_0001.
  - Required: gnt in the same cycle; psel at t+1, penable at t+2; r_valid at t+3 with rdata=32'hCAFE_0001, opc=0; pwrite=0, pstrb=0.
- Write with wait states:
  - Stimulus: wen=0, wdata=32'h0000_00FF, be=4'b0011; pready held low for 5 cycles.
  - Required: pwdata/pstrb/paddr stable for all 6 ACCESS cycles; r_valid pulse of 1 cycle with rdata=0, opc=0.
- Slave error:
  - Stimulus: read with pready=1, pslverr=1, prdata=32'h1234_5678.
  - Required: r_valid with opc=1, rdata=32'h1234_5678.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, pready stuck at 0.
  - Required: exactly 8 ACCESS cycles, then r_valid with opc=1, rdata=32'hBADACCE5; then a second request is granted normally. Repeat with pready rising on the 8th cycle and require opc=0.
- Back-to-back requests:
  - Stimulus: req held high for 3 transactions.
  - Required: gnt pulses exactly at 4-cycle spacing; three r_valid pulses in order, each with matching data.
- Reset mid-ACCESS:
  - Stimulus: rst_ni=0 for 1 cycle during ACCESS.
  - Required: psel/penable/r_valid all 0 from the next edge, no r_valid emitted, FSM in IDLE; the next request completes normally.
